fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 30 +++
 rtl/fetch_fifo.sv | 88 ++++++++
 rtl/fetch_unit.sv | 149 ++++++++++++++
 tb/tb_fetch_unit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
//   XLEN             : address/data width
//   RESET_PC_DEFAULT : default first fetch address after reset
//   IMEM_LATENCY     : cycles from request to returned data
//   FIFO_DEPTH       : instruction buffer depth (only 4 supported)
//   fetch_entry_t    : buffered {pc, instr} pair
//   inflight_t       : tracked outstanding request {valid, pc}
package fetch_pkg;

  localparam int unsigned XLEN             = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned IMEM_LATENCY     = 2;
  localparam int unsigned FIFO_DEPTH       = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
  } inflight_t;

  // Force a byte address onto a word boundary.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: DEPTH entries of fetch_entry_t with simultaneous
// push/pop and a synchronous flush (flush wins over push/pop).
// DEPTH must be a power of two so the pointers wrap naturally.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   flush_i      : drop all entries
//   push_i       : write push_data_i at the tail
//   pop_i        : remove the head entry (ignored when empty)
//   head_o       : head entry, all zero when empty
//   empty_o      : no entries held
//   count_o      : number of entries held
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  fetch_entry_t                 push_data_i,
  input  logic                         pop_i,
  output fetch_entry_t                 head_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push_c, do_pop_c;

  // Pointer/count update; a push into a full buffer is accepted only if a pop frees a slot.
  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    do_pop_c  = pop_i && (count_q != '0);
    do_push_c = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop_c);
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push_c) begin
        mem_d[wr_ptr_q] = push_data_i;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop_c) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push_c, do_pop_c})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; contents are only visible through a non-empty head, so no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign empty_o = (count_q == '0);
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential word fetches to a fixed-latency
// instruction memory, tracks outstanding requests, buffers returned
// instructions and presents them in order to decode.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (misaligned redirect fault).
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   stall_i             : decode hazard, hold the presented instruction
//   redirect_i          : taken branch/jump, refetch from redirect_pc_i
//   redirect_pc_i       : redirect target byte address
//   imem_read_en_o      : memory read request
//   imem_addr_o         : request byte address
//   imem_hazard_o       : copy of stall_i
//   imem_q_i            : memory read data, IMEM_LATENCY cycles after request
//   if_valid_o          : if_instr_o/if_pc_o hold a valid pair
//   if_instr_o, if_pc_o : presented instruction and its byte address
//   fault_o             : sticky misaligned-redirect flag (macro only)
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = fetch_pkg::RESET_PC_DEFAULT,
  parameter int unsigned FIFO_DEPTH = fetch_pkg::FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_read_en_o,
  output logic [31:0] imem_addr_o,
  output logic        imem_hazard_o,
  input  logic [31:0] imem_q_i,
  output logic        if_valid_o,
  output logic [31:0] if_instr_o,
  output logic [31:0] if_pc_o
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic        fault_o
`endif
);

  import fetch_pkg::*;

  localparam int unsigned CNT_W       = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OCC_W       = CNT_W + 1;
  localparam int unsigned ISSUE_LIMIT = FIFO_DEPTH - 1;

  logic [XLEN-1:0] pc_q, pc_d;
  inflight_t       pipe_q [IMEM_LATENCY];
  inflight_t       pipe_d [IMEM_LATENCY];
  inflight_t       ret_c;
  logic            issue_c, flush_c, push_c, pop_c, fault_c;
  logic [OCC_W-1:0] occupancy_c;
  fetch_entry_t    push_data_c, head_c;
  logic            empty_c;
  logic [CNT_W-1:0] count_c;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic fault_q, fault_d;

  // Sticky fault: set by a misaligned redirect, cleared by an aligned one.
  always_comb begin
    fault_d = fault_q;
    if (redirect_i) begin
      fault_d = (redirect_pc_i[1:0] != 2'b00);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  assign fault_c = fault_q;
  assign fault_o = rst_n & fault_q;
`else
  assign fault_c = 1'b0;
`endif

  // Oldest tracked request: when valid, imem_q_i belongs to its pc this cycle.
  assign ret_c       = pipe_q[IMEM_LATENCY-1];
  assign push_c      = ret_c.valid;
  assign push_data_c = '{pc: ret_c.pc, instr: imem_q_i};
  assign pop_c       = !empty_c && !stall_i;

  // Issue/redirect control. Buffered + outstanding entries are capped so every
  // returning word is guaranteed a FIFO slot (memory has no backpressure).
  always_comb begin
    pc_d        = pc_q;
    issue_c     = 1'b0;
    flush_c     = 1'b0;
    occupancy_c = OCC_W'(count_c);
    for (int unsigned i = 0; i < IMEM_LATENCY; i++) begin
      occupancy_c = occupancy_c + OCC_W'(pipe_q[i].valid);
    end
    pipe_d[0] = '0;
    for (int unsigned i = 1; i < IMEM_LATENCY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
    if (redirect_i) begin
      // Redirect beats stall: drop buffered and outstanding work, no request now.
      flush_c = 1'b1;
      for (int unsigned i = 0; i < IMEM_LATENCY; i++) begin
        pipe_d[i] = '0;
      end
      pc_d = align_word(redirect_pc_i);
    end else if (!fault_c && (occupancy_c <= OCC_W'(ISSUE_LIMIT))) begin
      issue_c   = 1'b1;
      pipe_d[0] = '{valid: 1'b1, pc: pc_q};
      pc_d      = pc_q + XLEN'(4);
    end
  end

  // Fetch pc and in-flight tracking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
      for (int unsigned i = 0; i < IMEM_LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pc_q   <= pc_d;
      pipe_q <= pipe_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush_c),
    .push_i      (push_c),
    .push_data_i (push_data_c),
    .pop_i       (pop_c),
    .head_o      (head_c),
    .empty_o     (empty_c),
    .count_o     (count_c)
  );

  // Everything is forced low while reset is applied.
  assign imem_read_en_o = rst_n & issue_c;
  assign imem_addr_o    = rst_n ? pc_q : '0;
  assign imem_hazard_o  = rst_n & stall_i;
  assign if_valid_o     = rst_n & ~empty_c;
  assign if_instr_o     = rst_n ? head_c.instr : '0;
  assign if_pc_o        = rst_n ? head_c.pc : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit. A queue-based reference model tracks
// outstanding requests and buffered instructions; memory word at byte
// address a holds a/4. Directed scenarios are followed by random
// stall/redirect/reset traffic. Honours FETCH_MISALIGN_CHECK_EN.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n, stall_i, redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_read_en_o, imem_hazard_o, if_valid_o;
  logic [31:0] imem_addr_o, imem_q_i, if_instr_o, if_pc_o;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        fault_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall_i        (stall_i),
    .redirect_i     (redirect_i),
    .redirect_pc_i  (redirect_pc_i),
    .imem_read_en_o (imem_read_en_o),
    .imem_addr_o    (imem_addr_o),
    .imem_hazard_o  (imem_hazard_o),
    .imem_q_i       (imem_q_i),
    .if_valid_o     (if_valid_o),
    .if_instr_o     (if_instr_o),
    .if_pc_o        (if_pc_o)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .fault_o        (fault_o)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {2'b00, a[31:2]};
  endfunction

  // Memory: answers every request two cycles later, unaware of redirects.
  logic        r1v, r2v;
  logic [31:0] r1a, r2a;
  always @(posedge clk) begin
    r1v <= imem_read_en_o;
    r1a <= imem_addr_o;
    r2v <= r1v;
    r2a <= r1a;
  end
  assign imem_q_i = r2v ? mem_word(r2a) : 32'hDEAD_BEEF;

  // Reference model state.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;
  typedef struct {
    logic [31:0] pc;
    int          due;
  } fl_t;

  ent_t        mfifo[$];
  fl_t         mflight[$];
  logic [31:0] m_pc    = RESET_PC;
  logic        m_fault = 1'b0;
  int          cyc     = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, compare at the falling edge, advance the model.
  task automatic cycle(input logic rst, input logic stl, input logic rdr, input logic [31:0] rpc);
    logic        exp_en, have_arr;
    logic [31:0] exp_pc, exp_instr;
    ent_t        arr;
    rst_n         = rst;
    stall_i       = stl;
    redirect_i    = rdr;
    redirect_pc_i = rpc;
    #4;
    exp_en    = rst && !rdr && !m_fault && ((mfifo.size() + mflight.size()) <= 3);
    exp_pc    = (rst && mfifo.size() != 0) ? mfifo[0].pc : 32'h0;
    exp_instr = (rst && mfifo.size() != 0) ? mfifo[0].instr : 32'h0;
    check("read_en", 32'(imem_read_en_o), 32'(exp_en));
    check("addr",    imem_addr_o, rst ? m_pc : 32'h0);
    check("hazard",  32'(imem_hazard_o), 32'(rst & stl));
    check("valid",   32'(if_valid_o), 32'(rst && mfifo.size() != 0));
    check("if_pc",   if_pc_o, exp_pc);
    check("if_instr", if_instr_o, exp_instr);
`ifdef FETCH_MISALIGN_CHECK_EN
    check("fault",   32'(fault_o), 32'(rst & m_fault));
`endif
    if (!rst) begin
      mfifo.delete();
      mflight.delete();
      m_pc    = RESET_PC;
      m_fault = 1'b0;
    end else begin
      have_arr = 1'b0;
      arr      = '{pc: 32'h0, instr: 32'h0};
      if (mflight.size() != 0 && mflight[0].due == cyc) begin
        have_arr  = 1'b1;
        arr.pc    = mflight[0].pc;
        arr.instr = mem_word(arr.pc);
        void'(mflight.pop_front());
      end
      if (rdr) begin
        mfifo.delete();
        mflight.delete();
        m_pc = {rpc[31:2], 2'b00};
`ifdef FETCH_MISALIGN_CHECK_EN
        m_fault = (rpc[1:0] != 2'b00);
`endif
      end else begin
        if (mfifo.size() != 0 && !stl) void'(mfifo.pop_front());
        if (have_arr) mfifo.push_back(arr);
        if (exp_en) begin
          mflight.push_back('{pc: m_pc, due: cyc + 2});
          m_pc = m_pc + 32'd4;
        end
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] tgt;
    logic        rs, st, rd;
    rst_n = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    @(posedge clk);
    #1;

    // Reset, then release: first valid three cycles after the first request.
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    check("reset_valid", 32'(if_valid_o), 32'd0);
    check("reset_read_en", 32'(imem_read_en_o), 32'd0);
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    check("first_valid", 32'(if_valid_o), 32'd1);
    check("first_pc", if_pc_o, 32'h0);
    check("first_instr", if_instr_o, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    check("second_pc", if_pc_o, 32'h4);
    check("second_instr", if_instr_o, 32'h1);
    repeat (8) cycle(1'b1, 1'b0, 1'b0, 32'h0);

    // Stall six cycles: head held, buffer fills, requests stop.
    repeat (6) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("stall_no_req", 32'(imem_read_en_o), 32'd0);
    repeat (10) cycle(1'b1, 1'b0, 1'b0, 32'h0);

    // Redirect with requests in flight.
    cycle(1'b1, 1'b0, 1'b1, 32'h100);
    check("redir_valid1", 32'(if_valid_o), 32'd0);
    check("redir_addr", imem_addr_o, 32'h100);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    check("redir_valid2", 32'(if_valid_o), 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    check("redir_valid3", 32'(if_valid_o), 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    check("redir_pc", if_pc_o, 32'h100);
    check("redir_instr", if_instr_o, 32'h40);
    repeat (4) cycle(1'b1, 1'b0, 1'b0, 32'h0);

    // Redirect and stall together, stall held afterwards.
    cycle(1'b1, 1'b1, 1'b1, 32'h100);
    repeat (6) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("rs_valid", 32'(if_valid_o), 32'd1);
    check("rs_pc", if_pc_o, 32'h100);
    repeat (6) cycle(1'b1, 1'b0, 1'b0, 32'h0);

    // Misaligned redirect.
    cycle(1'b1, 1'b0, 1'b1, 32'h102);
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 32'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
    check("mis_fault", 32'(fault_o), 32'd1);
    check("mis_valid", 32'(if_valid_o), 32'd0);
    check("mis_no_req", 32'(imem_read_en_o), 32'd0);
    cycle(1'b1, 1'b0, 1'b1, 32'h200);
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    check("mis_clear", 32'(fault_o), 32'd0);
    check("mis_resume_pc", if_pc_o, 32'h200);
`else
    check("mis_valid", 32'(if_valid_o), 32'd1);
    check("mis_pc", if_pc_o, 32'h100);
`endif
    repeat (4) cycle(1'b1, 1'b0, 1'b0, 32'h0);

    // Address wrap at the top of the address space.
    cycle(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
    check("wrap_addr0", imem_addr_o, 32'hFFFF_FFFC);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    check("wrap_addr1", imem_addr_o, 32'h0);
    repeat (2) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    check("wrap_pc", if_pc_o, 32'hFFFF_FFFC);
    check("wrap_instr", if_instr_o, 32'h3FFF_FFFF);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    check("wrap_next_pc", if_pc_o, 32'h0);
    repeat (4) cycle(1'b1, 1'b0, 1'b0, 32'h0);

    // Reset in mid-operation: stale returns dropped, restart at RESET_PC.
    repeat (2) cycle(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    check("rerst_valid", 32'(if_valid_o), 32'd1);
    check("rerst_pc", if_pc_o, RESET_PC);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      rs  = ($urandom_range(0, 99) != 0);
      st  = ($urandom_range(0, 9) < 3);
      rd  = ($urandom_range(0, 19) == 0);
      tgt = $urandom;
      if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
      cycle(rs, st, rd, tgt);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
